// File: rtl/tt_slot_scheduler.sv
// TDMA slot scheduler: steps through slots, stamps time and sequence into the
// payload RAM in owned slots, then launches a UDP frame and waits until it is sent.
module tt_slot_scheduler #(
    parameter int unsigned          SLOT_CYCLES = 1000,
    parameter int unsigned          NUM_SLOTS   = 4,
    parameter logic [NUM_SLOTS-1:0] OWN_MASK    = 4'b0101,
    parameter logic [8:0]           STAMP_ADDR  = 9'd2,
    parameter logic [31:0]          SYNC_OFFSET = 32'd3,
    localparam int unsigned         IW          = $clog2(NUM_SLOTS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          rx_wea,
    input  logic [8:0]    rx_addr,
    input  logic [31:0]   rx_din,
    output logic          ram_wea,
    output logic [8:0]    ram_addr,
    output logic [31:0]   ram_din,
    output logic          tx_start,
    input  logic          tx_busy,
    input  logic          sync_valid,
    input  logic [31:0]   sync_time,
    output logic [31:0]   local_time,
    output logic [IW-1:0] slot_idx,
    output logic [31:0]   tx_seq,
    output logic          missed_slot
);

    localparam logic [15:0] SLOT_LAST = 16'(SLOT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, STAMP_TS, STAMP_SEQ, START, WAIT_BUSY, WAIT_DONE
    } state_t;

    typedef struct packed {
        logic        wea;
        logic [8:0]  addr;
        logic [31:0] din;
    } ram_wr_t;

    state_t        state;
    logic [15:0]   slot_cnt;
    logic [31:0]   ts_latch;
    logic          slot_begin;
    logic          slot_end;
    logic          busy_next;
    logic [IW-1:0] next_idx;
    ram_wr_t       ram_wr;

    assign slot_begin = (slot_cnt == 16'd0);
    assign slot_end   = (slot_cnt == SLOT_LAST);
    assign next_idx   = slot_idx + IW'(1);
    // FSM will still be mid-sequence next cycle; lets missed_slot line up with slot_begin.
    assign busy_next  = (state != IDLE) && !(state == WAIT_DONE && !tx_busy);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            slot_cnt    <= '0;
            slot_idx    <= '0;
            local_time  <= '0;
            tx_seq      <= '0;
            ts_latch    <= '0;
            tx_start    <= 1'b0;
            missed_slot <= 1'b0;
        end else begin
            slot_cnt    <= slot_end ? 16'd0 : slot_cnt + 16'd1;
            if (slot_end)
                slot_idx <= next_idx;
            local_time  <= sync_valid ? sync_time + SYNC_OFFSET : local_time + 32'd1;
            missed_slot <= slot_end && OWN_MASK[next_idx] && busy_next;
            tx_start    <= 1'b0;

            case (state)
                IDLE: if (slot_begin && OWN_MASK[slot_idx]) begin
                    state    <= STAMP_TS;
                    ts_latch <= local_time;
                end
                STAMP_TS:  if (!rx_wea) state <= STAMP_SEQ;
                STAMP_SEQ: if (!rx_wea) begin
                    state    <= START;
                    tx_start <= 1'b1;
                end
                START:     state <= WAIT_BUSY;
                WAIT_BUSY: if (tx_busy) state <= WAIT_DONE;
                WAIT_DONE: if (!tx_busy) begin
                    state  <= IDLE;
                    tx_seq <= tx_seq + 32'd1;
                end
                default:   state <= IDLE;
            endcase
        end
    end

    // Receive path always wins the RAM port; stamp states simply hold until it is free.
    always_comb begin
        ram_wr = '0;
        if (rx_wea)
            ram_wr = '{wea: 1'b1, addr: rx_addr, din: rx_din};
        else if (state == STAMP_TS)
            ram_wr = '{wea: 1'b1, addr: STAMP_ADDR, din: ts_latch};
        else if (state == STAMP_SEQ)
            ram_wr = '{wea: 1'b1, addr: STAMP_ADDR + 9'd2, din: tx_seq + 32'd1};
    end

    assign ram_wea  = ram_wr.wea;
    assign ram_addr = ram_wr.addr;
    assign ram_din  = ram_wr.din;

endmodule

// File: tb/tb_tt_slot_scheduler.sv
// Bench for tt_slot_scheduler: per-cycle model comparison plus directed scenarios
// with hand-computed event logs (stamp writes, tx_start, missed_slot).
module tb_tt_slot_scheduler;

    localparam int          SC  = 1000;
    localparam int          NS  = 4;
    localparam logic [3:0]  OWN = 4'b0101;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_wea = 1'b0;
    logic [8:0]  rx_addr = '0;
    logic [31:0] rx_din = '0;
    logic        ram_wea;
    logic [8:0]  ram_addr;
    logic [31:0] ram_din;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic        sync_valid = 1'b0;
    logic [31:0] sync_time = '0;
    logic [31:0] local_time;
    logic [1:0]  slot_idx;
    logic [31:0] tx_seq;
    logic        missed_slot;

    tt_slot_scheduler dut (
        .clk(clk), .reset_n(reset_n),
        .rx_wea(rx_wea), .rx_addr(rx_addr), .rx_din(rx_din),
        .ram_wea(ram_wea), .ram_addr(ram_addr), .ram_din(ram_din),
        .tx_start(tx_start), .tx_busy(tx_busy),
        .sync_valid(sync_valid), .sync_time(sync_time),
        .local_time(local_time), .slot_idx(slot_idx),
        .tx_seq(tx_seq), .missed_slot(missed_slot)
    );

    always #4 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endfunction

    typedef struct {
        int          cyc;
        logic [8:0]  a;
        logic [31:0] d;
    } wr_t;

    // Event logs of what the DUT actually did, cleared per scenario.
    wr_t wlog[$];
    int  start_q[$];
    int  missed_q[$];

    // Behavioural model: pending stamp writes as a queue, transmission as flags.
    int          t;
    logic [31:0] m_time, m_seq;
    bit          active, start_now, watching, busy_seen;
    wr_t         sq[$];
    int          e_idx;
    bit          begin_now, owned, e_missed, was_active, next_start;
    logic        ew;
    logic [8:0]  ea;
    logic [31:0] ed;
    wr_t         w;

    always @(negedge clk) begin
        if (!reset_n) begin
            t = 0; m_time = 0; m_seq = 0;
            active = 0; start_now = 0; watching = 0; busy_seen = 0;
            sq.delete();
        end else begin
            e_idx     = (t / SC) % NS;
            begin_now = (t % SC) == 0;
            owned     = OWN[e_idx];
            e_missed  = begin_now && owned && active;
            if (rx_wea) begin
                ew = 1; ea = rx_addr; ed = rx_din;
            end else if (sq.size() > 0) begin
                ew = 1; ea = sq[0].a; ed = sq[0].d;
            end else begin
                ew = 0; ea = 0; ed = 0;
            end
            chk("ram_wea", 32'(ram_wea), 32'(ew));
            chk("ram_addr", 32'(ram_addr), 32'(ea));
            chk("ram_din", ram_din, ed);
            chk("tx_start", 32'(tx_start), 32'(start_now));
            chk("missed_slot", 32'(missed_slot), 32'(e_missed));
            chk("local_time", local_time, m_time);
            chk("slot_idx", 32'(slot_idx), 32'(e_idx));
            chk("tx_seq", tx_seq, m_seq);

            if (ram_wea && !rx_wea) begin
                w.cyc = t; w.a = ram_addr; w.d = ram_din;
                wlog.push_back(w);
            end
            if (tx_start)    start_q.push_back(t);
            if (missed_slot) missed_q.push_back(t);

            was_active = active;
            next_start = 0;
            if (!rx_wea && sq.size() > 0) begin
                void'(sq.pop_front());
                if (sq.size() == 0) next_start = 1;
            end
            if (busy_seen && !tx_busy) begin
                m_seq++; active = 0; busy_seen = 0; watching = 0;
            end else if (watching && tx_busy) begin
                busy_seen = 1;
            end
            if (start_now) watching = 1;
            if (begin_now && owned && !was_active) begin
                active = 1;
                w.cyc = 0; w.a = 9'd2; w.d = m_time;
                sq.push_back(w);
                w.a = 9'd4; w.d = m_seq + 1;
                sq.push_back(w);
            end
            m_time    = sync_valid ? sync_time + 32'd3 : m_time + 32'd1;
            start_now = next_start;
            t++;
        end
    end

    int busy_left = 0;

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 0; rx_wea = 0; rx_addr = 0; rx_din = 0;
        tx_busy = 0; sync_valid = 0; sync_time = 0; busy_left = 0;
        @(posedge clk); #1;
    endtask

    // resp>0: tx_busy goes high for resp cycles after each tx_start.
    task automatic run(int scen, int ncyc, int rx_from, int rx_to, int resp,
                       int bfrom, int bto, int sync_at);
        wlog.delete(); start_q.delete(); missed_q.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            reset_n    = 1;
            rx_wea     = (c >= rx_from && c <= rx_to);
            rx_addr    = rx_wea ? 9'd9 : 9'($urandom);
            rx_din     = rx_wea ? 32'hA5A5A5A5 : $urandom;
            sync_valid = (c == sync_at);
            sync_time  = sync_valid ? 32'h00001000 : $urandom;
            tx_busy    = (c >= bfrom && c <= bto) || busy_left > 0;
            if (busy_left > 0) busy_left--;
            @(negedge clk);
            if (tx_start && resp > 0) busy_left = resp;
            case (scen)
                1: begin
                    if (c == 24)   chk("s1_seq_before_fall", tx_seq, 0);
                    if (c == 25)   chk("s1_seq_after_fall", tx_seq, 1);
                    if (c == 4029) chk("s1_seq_final", tx_seq, 3);
                end
                2: if (c == 3) begin
                    chk("s2_rx_wea", 32'(ram_wea), 1);
                    chk("s2_rx_addr", 32'(ram_addr), 9);
                    chk("s2_rx_din", ram_din, 32'hA5A5A5A5);
                end
                4: begin
                    if (c == 500)  chk("s4_time_pre_sync", local_time, 32'd500);
                    if (c == 501)  chk("s4_time_post_sync", local_time, 32'h00001003);
                    if (c == 1000) chk("s4_slot_idx", 32'(slot_idx), 1);
                end
                6: begin
                    if (c == 0) begin
                        chk("s6_rst_seq", tx_seq, 0);
                        chk("s6_rst_time", local_time, 0);
                        chk("s6_rst_idx", 32'(slot_idx), 0);
                        chk("s6_rst_start", 32'(tx_start), 0);
                        chk("s6_rst_missed", 32'(missed_slot), 0);
                        chk("s6_rst_wea", 32'(ram_wea), 0);
                    end
                    if (c == 25) chk("s6_seq_after_fall", tx_seq, 1);
                end
                default: ;
            endcase
        end
    endtask

    task automatic chk_wr(string nm, int i, int cyc, int a, logic [31:0] d);
        chk({nm, "_cyc"}, wlog.size() > i ? wlog[i].cyc : -1, cyc);
        chk({nm, "_addr"}, wlog.size() > i ? 32'(wlog[i].a) : 32'hFFFFFFFF, a);
        chk({nm, "_data"}, wlog.size() > i ? wlog[i].d : 32'hFFFFFFFF, d);
    endtask

    function automatic int qat(int q[$], int i);
        return q.size() > i ? q[i] : -1;
    endfunction

    initial begin
        // Scenario 1: default timing across all four slots, busy 20 cycles per frame.
        do_reset();
        run(1, 4030, 1, 0, 20, 1, 0, -1);
        chk("s1_n_wr", wlog.size(), 6);
        chk_wr("s1_w0", 0, 1, 2, 0);
        chk_wr("s1_w1", 1, 2, 4, 1);
        chk_wr("s1_w2", 2, 2001, 2, 2000);
        chk_wr("s1_w3", 3, 2002, 4, 2);
        chk_wr("s1_w5", 5, 4002, 4, 3);
        chk("s1_n_start", start_q.size(), 3);
        chk("s1_start0", qat(start_q, 0), 3);
        chk("s1_start1", qat(start_q, 1), 2003);
        chk("s1_n_missed", missed_q.size(), 0);

        // Scenario 2: rx contention on cycles 1..4 delays stamping.
        do_reset();
        run(2, 30, 1, 4, 20, 1, 0, -1);
        chk("s2_n_wr", wlog.size(), 2);
        chk_wr("s2_w0", 0, 5, 2, 0);
        chk_wr("s2_w1", 1, 6, 4, 1);
        chk("s2_n_start", start_q.size(), 1);
        chk("s2_start0", qat(start_q, 0), 7);

        // Scenario 3: busy held for 2500 cycles, slot 2 is missed.
        do_reset();
        run(3, 4010, 1, 0, 0, 0, 2499, -1);
        chk("s3_n_missed", missed_q.size(), 1);
        chk("s3_missed0", qat(missed_q, 0), 2000);
        chk("s3_n_start", start_q.size(), 2);
        chk("s3_start1", qat(start_q, 1), 4003);
        chk("s3_n_wr", wlog.size(), 4);
        chk_wr("s3_w3", 3, 4002, 4, 2);
        chk("s3_seq_final", tx_seq, 1);

        // Scenario 4: time sync at cycle 500 leaves slot timing alone.
        do_reset();
        run(4, 2010, 1, 0, 20, 1, 0, 500);
        chk("s4_n_start", start_q.size(), 2);
        chk("s4_start1", qat(start_q, 1), 2003);
        chk_wr("s4_w2", 2, 2001, 2, 32'h000015DE);

        // Scenarios 5/6: reset during WAIT_DONE, then a clean restart.
        do_reset();
        run(5, 10, 1, 0, 20, 1, 0, -1);
        chk("s5_seq_mid", tx_seq, 0);
        do_reset();
        run(6, 30, 1, 0, 20, 1, 0, -1);
        chk("s6_n_wr", wlog.size(), 2);
        chk_wr("s6_w1", 1, 2, 4, 1);
        chk("s6_start0", qat(start_q, 0), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_slot_scheduler.md
TT_SLOT_SCHEDULER -- requirements
Module: tt_slot_scheduler

Interface
REQ-001 Parameter SLOT_CYCLES, default 1000: clock cycles per TDMA slot, legal range 8..65535.
REQ-002 Parameter NUM_SLOTS, default 4: slots per round, power of two, 2..16.
REQ-003 Parameter OWN_MASK, default 4'b0101: bit n = 1 means slot n is owned by this node for transmission.
REQ-004 Parameter STAMP_ADDR, default 9'd2: payload RAM word for the timestamp; the sequence number goes to STAMP_ADDR+2.
REQ-005 Parameter SYNC_OFFSET, default 32'd3: path-delay compensation added on time sync.
REQ-006 clk  in  1  125 MHz GMII rx clock; every register is rising-edge.
REQ-007 reset_n  in  1  synchronous, active-low reset.
REQ-008 rx_wea  in  1  write request from the UDP receive path.
REQ-009 rx_addr  in  9  receive-path write address.
REQ-010 rx_din  in  32  receive-path write data.
REQ-011 ram_wea  out  1  arbitrated payload RAM write enable.
REQ-012 ram_addr  out  9  arbitrated payload RAM write address.
REQ-013 ram_din  out  32  arbitrated payload RAM write data.
REQ-014 tx_start  out  1  one-cycle pulse that launches a UDP frame.
REQ-015 tx_busy  in  1  high while the UDP transmitter is sending.
REQ-016 sync_valid  in  1  one-cycle strobe: the peer's time has been received.
REQ-017 sync_time  in  32  peer time value, valid with sync_valid.
REQ-018 local_time  out  32  free-running local time.
REQ-019 slot_idx  out  log2(NUM_SLOTS)  index of the current slot.
REQ-020 tx_seq  out  32  count of completed transmissions.
REQ-021 missed_slot  out  1  one-cycle pulse: an owned slot began while a transmission was still in progress.

Function
REQ-022 Slot counter: slot_cnt counts 0..SLOT_CYCLES-1 and wraps to 0; on each wrap slot_idx increments modulo NUM_SLOTS.
REQ-023 slot_begin is defined as slot_cnt==0; the slot counter is not affected by sync.
REQ-024 local_time increments by 1 every cycle and wraps modulo 2^32.
REQ-025 When sync_valid=1, local_time loads sync_time+SYNC_OFFSET (mod 2^32) that cycle; sync overrides the increment.
REQ-026 FSM states: IDLE, STAMP_TS, STAMP_SEQ, START, WAIT_BUSY, WAIT_DONE.
REQ-027 IDLE -> STAMP_TS when slot_begin and OWN_MASK[slot_idx]=1; ts_latch captures local_time in that same cycle.
REQ-028 STAMP_TS issues a write of ts_latch to STAMP_ADDR, then moves to STAMP_SEQ.
REQ-029 STAMP_SEQ issues a write of tx_seq+1 to STAMP_ADDR+2, then moves to START.
REQ-030 START asserts tx_start for exactly one cycle, then moves to WAIT_BUSY.
REQ-031 WAIT_BUSY stays until tx_busy=1, then moves to WAIT_DONE.
REQ-032 WAIT_DONE stays until tx_busy=0, then moves to IDLE and increments tx_seq (wraps modulo 2^32).
REQ-033 Arbitration: rx_wea has absolute priority. When rx_wea=1, ram_* = rx_*, and any STAMP_TS/STAMP_SEQ state holds without advancing.
REQ-034 RAM outputs when rx_wea=0:
- in a STAMP state, ram_wea=1 with the stamp address/data;
- otherwise ram_wea=0, ram_addr=0, ram_din=0.
REQ-035 The RAM outputs are combinational from the state and the rx_* inputs, so writes land in the same cycle.
REQ-036 Latency from an owned slot_begin to tx_start is 3 cycles when there is no rx contention, plus 1 cycle per contended stamp cycle.
REQ-037 If an owned slot_begin occurs while the FSM is not IDLE: pulse missed_slot for 1 cycle, start no new transmission, and do not disturb the current one.
REQ-038 Non-owned slots never start a transmission.

Reset
REQ-039 While reset_n=0 at a clock edge, all of the following clear to 0: slot_cnt, slot_idx, local_time, tx_seq, ts_latch, tx_start, missed_slot.
REQ-040 Reset also puts the FSM in IDLE.
REQ-041 Reset mid-transmission aborts the sequence; tx_seq is not incremented.
REQ-042 After reset_n returns to 1, slot 0 begins on the first cycle, so the default OWN_MASK triggers immediately.

Verification
REQ-043 Default parameters, release reset, model tx_busy high for 20 cycles after tx_start -> expect:
- writes (2, 0) then (4, 1);
- tx_start on cycle 3;
- tx_seq=1 after busy falls.
REQ-044 Hold rx_wea=1 for cycles 1..4 with rx_addr=9, rx_din=32'hA5A5A5A5 -> expect:
- RAM port shows the rx writes on those cycles;
- stamp writes occur on cycles 5 and 6;
- tx_start on cycle 7.
REQ-045 Hold tx_busy high for 2500 cycles -> expect missed_slot pulse at slot 2 begin (cycle 2000), with no extra tx_start.
REQ-046 sync_valid with sync_time=32'h00001000 at cycle 500 -> local_time=32'h00001003 at cycle 501; slot timing unchanged.
REQ-047 Slots 1 and 3 (non-owned) -> no RAM stamp writes and no tx_start.
REQ-048 Assert reset_n=0 during WAIT_DONE -> FSM returns to IDLE, tx_seq=0, and all outputs clear.
